// File: rtl/gcd_axi_result_reader.sv
// AXI4 read-channel master that pulls GCD result words in 4KB-safe INCR bursts and streams them out.
// Optional busy-cycle counter PERF_CYCLES is built when GCD_RD_PERF_EN is defined.

module gcd_axi_result_reader #(
  parameter logic [3:0]  AXI_ID     = 4'h0,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        CLK_DIV_8,
  input  logic        RESETn,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [31:0] CMD_ADDR,
  input  logic [11:0] CMD_BEATS,
  output logic [3:0]  M_AXI_ARID,
  output logic [31:0] M_AXI_ARADDR,
  output logic [7:0]  M_AXI_ARLEN,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [3:0]  M_AXI_RID,
  input  logic [63:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RLAST,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY,
  output logic [63:0] OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        OUT_LAST,
  output logic        BUSY,
  output logic        ERR
`ifdef GCD_RD_PERF_EN
  ,
  output logic [15:0] PERF_CYCLES
`endif
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LEN_W  = 9;
  localparam int unsigned CALC_W = 13;

  typedef enum logic [2:0] {S_IDLE, S_CREDIT, S_ADDR, S_DATA, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [11:0]        remaining_q, remaining_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [31:0]        araddr_d;
  logic [7:0]         arlen_d;
  logic               err_d, cmd_ready_d, busy_d, arvalid_d, rready_d, out_valid_d;

  logic [64:0]        fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [CALC_W-1:0]  bnd_beats_c, len_calc_c;
  logic [LEN_W-1:0]   len_c;
  logic               credit_ok_c, push_c, pop_c, beat_last_c, last_flag_c;
  logic               unused_addr_lsb_c;

  assign unused_addr_lsb_c = ^CMD_ADDR[2:0];
  assign M_AXI_ARID        = AXI_ID;

  assign push_c      = (state_q == S_DATA) && M_AXI_RVALID && M_AXI_RREADY;
  assign pop_c       = OUT_VALID && OUT_READY;
  assign beat_last_c = (beat_cnt_q + LEN_W'(1)) == len_q;
  assign last_flag_c = beat_last_c && (remaining_q == '0);

  assign OUT_DATA = fifo_q[rd_ptr_q][63:0];
  assign OUT_LAST = OUT_VALID && fifo_q[rd_ptr_q][64];

  // Burst length: remaining beats, clipped to MAX_BURST and to the next 4KB page.
  always_comb begin
    bnd_beats_c = (CALC_W'(4096) - CALC_W'(addr_q[11:0])) >> 3;
    len_calc_c  = CALC_W'(remaining_q);
    if (len_calc_c > CALC_W'(MAX_BURST)) len_calc_c = CALC_W'(MAX_BURST);
    if (len_calc_c > bnd_beats_c)        len_calc_c = bnd_beats_c;
    len_c       = LEN_W'(len_calc_c);
    // Only one burst is ever in flight, so nothing else needs to be reserved.
    credit_ok_c = (CALC_W'(FIFO_DEPTH) - CALC_W'(count_q)) >= CALC_W'(len_c);
  end

  always_comb begin
    count_d = count_q;
    if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
    else if (!push_c && pop_c) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge CLK_DIV_8 or negedge RESETn) begin
    if (!RESETn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (CMD_VALID && (CMD_BEATS != '0)) state_d = S_CREDIT;
      S_CREDIT: if (credit_ok_c) state_d = S_ADDR;
      S_ADDR:   if (M_AXI_ARREADY) state_d = S_DATA;
      S_DATA:   if (push_c && beat_last_c) state_d = (remaining_q != '0) ? S_CREDIT : S_DONE;
      S_DONE:   if (count_d == '0) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values for datapath registers and registered outputs.
  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    araddr_d    = M_AXI_ARADDR;
    arlen_d     = M_AXI_ARLEN;
    err_d       = ERR;
    case (state_q)
      S_IDLE: if (CMD_VALID) begin
        addr_d      = {CMD_ADDR[31:3], 3'b000};
        remaining_d = CMD_BEATS;
        err_d       = 1'b0;
      end
      S_CREDIT: if (credit_ok_c) begin
        len_d    = len_c;
        araddr_d = addr_q;
        arlen_d  = 8'(len_c - LEN_W'(1));
      end
      S_ADDR: if (M_AXI_ARREADY) begin
        addr_d      = addr_q + 32'({len_q, 3'b000});
        remaining_d = remaining_q - 12'(len_q);
        beat_cnt_d  = '0;
      end
      S_DATA: if (push_c) begin
        beat_cnt_d = beat_cnt_q + LEN_W'(1);
        if ((M_AXI_RRESP != 2'b00) || (M_AXI_RID != AXI_ID) || (M_AXI_RLAST != beat_last_c))
          err_d = 1'b1;
      end
      default: ;
    endcase
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    arvalid_d   = (state_d == S_ADDR);
    rready_d    = (count_d != CNT_W'(FIFO_DEPTH));
    out_valid_d = (count_d != '0);
  end

  always_ff @(posedge CLK_DIV_8 or negedge RESETn) begin
    if (!RESETn) begin
      addr_q        <= '0;
      remaining_q   <= '0;
      len_q         <= '0;
      beat_cnt_q    <= '0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARLEN   <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      CMD_READY     <= 1'b1;
      BUSY          <= 1'b0;
      ERR           <= 1'b0;
      OUT_VALID     <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      len_q         <= len_d;
      beat_cnt_q    <= beat_cnt_d;
      M_AXI_ARADDR  <= araddr_d;
      M_AXI_ARLEN   <= arlen_d;
      M_AXI_ARVALID <= arvalid_d;
      M_AXI_RREADY  <= rready_d;
      CMD_READY     <= cmd_ready_d;
      BUSY          <= busy_d;
      ERR           <= err_d;
      OUT_VALID     <= out_valid_d;
    end
  end

  // Read-data FIFO; each entry carries the end-of-command flag in bit 64.
  always_ff @(posedge CLK_DIV_8 or negedge RESETn) begin
    if (!RESETn) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        fifo_q[wr_ptr_q] <= {last_flag_c, M_AXI_RDATA};
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

`ifdef GCD_RD_PERF_EN
  always_ff @(posedge CLK_DIV_8 or negedge RESETn) begin
    if (!RESETn)                             PERF_CYCLES <= '0;
    else if ((state_q == S_IDLE) && CMD_VALID) PERF_CYCLES <= '0;
    else if (BUSY && (PERF_CYCLES != 16'hFFFF)) PERF_CYCLES <= PERF_CYCLES + 16'd1;
  end
`endif

endmodule
